// File: rtl/conv_mac_engine.sv
// conv_mac_engine
//   Streaming convolution MAC engine. Accepts K*K*IN_CH (activation, weight) tap pairs per
//   output pixel, accumulates their signed products, adds a per-pixel bias, shifts and
//   saturates the result, and emits one pixel per window over a valid/ready handshake.
//   A run of cfg_npix_i pixels is launched by start_i and finishes with a one-cycle done_o.
//
// Optional feature: define CONV_RELU_EN to clamp negative results to 0 before saturation.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      start a run (sampled in IDLE only)
//   cfg_npix_i   pixels per run, sampled with start_i
//   bias_i       bias, sampled on the first tap of each pixel
//   act_i        signed activation tap
//   wgt_i        signed weight tap
//   in_valid_i   tap pair valid
//   in_ready_o   tap pair accepted when in_valid_i & in_ready_o (ACC state only)
//   out_data_o   requantised pixel
//   out_valid_o  pixel valid, held until out_ready_i
//   out_ready_i  downstream ready
//   busy_o       high in any state but IDLE
//   done_o       one-cycle pulse at the end of a run
module conv_mac_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WGT_W  = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned IN_CH  = 3,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [15:0]              cfg_npix_i,
    input  logic signed [ACC_W-1:0]  bias_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [WGT_W-1:0]  wgt_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic signed [OUT_W-1:0]  out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned TAPS   = K * K * IN_CH;
    localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PROD_W = DATA_W + WGT_W;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAcc, StEmit, StDone} state_e;

    state_e r_state;
    state_e w_state_next;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_bias;
    logic [TAP_W-1:0]        r_tap_cnt;
    logic [15:0]             r_pix_cnt;
    logic [15:0]             r_npix;
    logic signed [OUT_W-1:0] r_out_data;

    logic                     w_tap_fire;
    logic                     w_out_fire;
    logic                     w_last_tap;
    logic                     w_last_pix;
    logic signed [PROD_W-1:0] w_act_ext;
    logic signed [PROD_W-1:0] w_wgt_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_bias_eff;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [ACC_W-1:0]  w_clamped;
    logic signed [OUT_W-1:0]  w_sat;

    assign in_ready_o  = (r_state == StAcc);
    assign out_valid_o = (r_state == StEmit);
    assign busy_o      = (r_state != StIdle);
    assign done_o      = (r_state == StDone);
    assign out_data_o  = r_out_data;

    assign w_tap_fire = in_valid_i & in_ready_o;
    assign w_out_fire = out_valid_o & out_ready_i;
    assign w_last_tap = (r_tap_cnt == LAST_TAP);
    assign w_last_pix = (r_pix_cnt == (r_npix - 16'd1));

    // Operands are sign-extended to the full product width so the low PROD_W bits are exact.
    assign w_act_ext  = {{WGT_W{act_i[DATA_W-1]}}, act_i};
    assign w_wgt_ext  = {{DATA_W{wgt_i[WGT_W-1]}}, wgt_i};
    assign w_prod     = w_act_ext * w_wgt_ext;
    assign w_acc_next = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // On the first tap the bias register has not been loaded yet, so use the live input.
    assign w_bias_eff = (r_tap_cnt == '0) ? bias_i : r_bias;
    assign w_sum      = w_acc_next + w_bias_eff;
    assign w_shifted  = w_sum >>> SHIFT;

`ifdef CONV_RELU_EN
    assign w_clamped = w_shifted[ACC_W-1] ? '0 : w_shifted;
`else
    assign w_clamped = w_shifted;
`endif

    always_comb begin
        w_sat = w_clamped[OUT_W-1:0];
        if (w_clamped > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (w_clamped < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_next = (cfg_npix_i == 16'd0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (w_tap_fire && w_last_tap) begin
                    w_state_next = StEmit;
                end
            end
            StEmit: begin
                if (w_out_fire) begin
                    w_state_next = w_last_pix ? StDone : StAcc;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_bias     <= '0;
            r_tap_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_npix     <= '0;
            r_out_data <= '0;
        end else begin
            if ((r_state == StIdle) && start_i) begin
                r_npix    <= cfg_npix_i;
                r_pix_cnt <= '0;
                r_tap_cnt <= '0;
                r_acc     <= '0;
            end
            if (w_tap_fire) begin
                if (r_tap_cnt == '0) begin
                    r_bias <= bias_i;
                end
                if (w_last_tap) begin
                    // Clearing here leaves the accumulator ready for the next pixel's first tap.
                    r_tap_cnt  <= '0;
                    r_acc      <= '0;
                    r_out_data <= w_sat;
                end else begin
                    r_tap_cnt <= r_tap_cnt + TAP_W'(1);
                    r_acc     <= w_acc_next;
                end
            end
            if (w_out_fire) begin
                r_pix_cnt <= r_pix_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine
//   Three engine instances share one stimulus bus: u0 with default parameters (27 taps),
//   u1 with K=3/IN_CH=1 (9 taps), u2 with K=3/IN_CH=1/SHIFT=2. Only the instance selected
//   by sel receives start_i, so the others stay idle and never accept taps.
//   Expected pixels come from an arithmetic model fed by the tap driver.
`timescale 1ns/1ps
module tb_conv_mac_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                start;
    logic [15:0]         npix;
    logic signed [31:0]  bias;
    logic signed [7:0]   act;
    logic signed [7:0]   wgt;
    logic                in_valid;
    logic                out_ready;
    int                  sel;
    logic [2:0]          start_v;
    logic [2:0]          in_ready;
    logic [2:0]          out_valid;
    logic [2:0]          busy;
    logic [2:0]          done;
    logic signed [7:0]   out_data [3];

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [7:0] exp_q[$];
    logic signed [7:0] last_exp;

    assign start_v = start ? 3'(3'b001 << sel) : 3'b000;

    conv_mac_engine u0 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_v[0]), .cfg_npix_i(npix), .bias_i(bias),
        .act_i(act), .wgt_i(wgt), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .out_data_o(out_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .busy_o(busy[0]), .done_o(done[0])
    );

    conv_mac_engine #(.K(3), .IN_CH(1)) u1 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_v[1]), .cfg_npix_i(npix), .bias_i(bias),
        .act_i(act), .wgt_i(wgt), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .out_data_o(out_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .busy_o(busy[1]), .done_o(done[1])
    );

    conv_mac_engine #(.K(3), .IN_CH(1), .SHIFT(2)) u2 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start_v[2]), .cfg_npix_i(npix), .bias_i(bias),
        .act_i(act), .wgt_i(wgt), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
        .out_data_o(out_data[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
        .busy_o(busy[2]), .done_o(done[2])
    );

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int taps_of(input int s);
        return (s == 0) ? 27 : 9;
    endfunction

    function automatic int shift_of(input int s);
        return (s == 2) ? 2 : 0;
    endfunction

    // Pixel value from the plain arithmetic definition: 32-bit wrap, shift, clamp.
    function automatic logic signed [7:0] model_pix(input longint sum, input longint b,
                                                    input int sh);
        logic signed [31:0] s32;
        longint v;
        s32 = 32'(sum + b);
        v = longint'(s32) >>> sh;
`ifdef CONV_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return 8'(v);
    endfunction

    task automatic do_start(input logic [15:0] n);
        npix = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_tap(input logic signed [7:0] a, input logic signed [7:0] w);
        int n = 0;
        act = a;
        wgt = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("tap accept timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Taps follow act = a0 + i*ast, wgt = w0 + i*wst; a start pulse rides on tap 'glitch'.
    task automatic send_pixel(input int a0, input int ast, input int w0, input int wst,
                              input int b, input int glitch);
        longint sum = 0;
        logic signed [7:0] a;
        logic signed [7:0] w;
        bias = b;
        for (int i = 0; i < taps_of(sel); i++) begin
            a = 8'(a0 + i * ast);
            w = 8'(w0 + i * wst);
            sum += longint'(a) * longint'(w);
            if (i == glitch) begin
                start = 1'b1;
                npix = 16'd5;
            end
            send_tap(a, w);
            start = 1'b0;
        end
        last_exp = model_pix(sum, b, shift_of(sel));
        exp_q.push_back(last_exp);
        check("emit latency", out_valid[sel], 1);
        check("no tap in EMIT", in_ready[sel], 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done[sel] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " done seen"}, done[sel], 1);
        check({name, " no valid in DONE"}, out_valid[sel], 0);
        @(posedge clk); #1;
        check({name, " done one cycle"}, done[sel], 0);
        check({name, " idle after done"}, busy[sel], 0);
    endtask

    task automatic check_all_zero(input string name, input int s);
        check({name, " in_ready"}, in_ready[s], 0);
        check({name, " out_valid"}, out_valid[s], 0);
        check({name, " busy"}, busy[s], 0);
        check({name, " done"}, done[s], 0);
        check({name, " out_data"}, out_data[s], 0);
    endtask

    // Compare process: every pixel handshake against the model queue, plus hold behaviour.
    logic              prev_stall = 1'b0;
    logic signed [7:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("ready/valid exclusive", in_ready[sel] & out_valid[sel], 0);
            if (prev_stall) begin
                check("hold valid", out_valid[sel], 1);
                check("hold data", out_data[sel], prev_data);
            end
            if (out_valid[sel] && out_ready) begin
                if (exp_q.size() == 0) check("unexpected pixel", 1, 0);
                else check("pixel vs model", out_data[sel], exp_q.pop_front());
            end
            prev_stall = out_valid[sel] && !out_ready;
            prev_data  = out_data[sel];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; npix = '0; bias = '0; act = '0; wgt = '0;
        in_valid = 1'b0; out_ready = 1'b1; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check_all_zero("reset", s);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 9 taps of 1*2 -> 18, done one cycle after the handshake.
        sel = 1;
        do_start(16'd1);
        send_pixel(1, 0, 2, 0, 0, -1);
        check("t1 literal 18", out_data[1], 18);
        @(posedge clk); #1;
        check("t1 done after handshake", done[1], 1);
        wait_done("t1");

        // 2: saturation at both ends on 27 taps.
        sel = 0;
        do_start(16'd2);
        send_pixel(127, 0, 127, 0, 0, -1);
        check("t2 literal 127", out_data[0], 127);
        send_pixel(-128, 0, 127, 0, 0, -1);
`ifdef CONV_RELU_EN
        check("t2 literal relu 0", out_data[0], 0);
`else
        check("t2 literal -128", out_data[0], -128);
`endif
        wait_done("t2");

        // 3: bias -20, shift 2: (81-20)>>>2 = 15.
        sel = 2;
        do_start(16'd1);
        send_pixel(3, 0, 3, 0, -20, -1);
        check("t3 literal 15", out_data[2], 15);
        wait_done("t3");

        // 4: downstream stall for 5 cycles with a tap offered; nothing may be consumed.
        sel = 1;
        do_start(16'd2);
        out_ready = 1'b0;
        send_pixel(-20, 5, 7, -1, 10, -1);
        act = 8'sd100; wgt = 8'sd100; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t4 stall in_ready", in_ready[1], 0);
            check("t4 stall data", out_data[1], last_exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_pixel(9, -2, -3, 1, 100, -1);
        wait_done("t4");

        // 5: zero-pixel run, then a start pulse during ACC that must be ignored.
        do_start(16'd0);
        check("t5 npix0 done", done[1], 1);
        check("t5 npix0 no valid", out_valid[1], 0);
        @(posedge clk); #1;
        check("t5 npix0 done cleared", done[1], 0);
        check("t5 npix0 idle", busy[1], 0);
        do_start(16'd1);
        send_pixel(2, 1, -3, 0, 5, 4);
        wait_done("t5");
        check("t5 single pixel", exp_q.size(), 0);

        // 6: asynchronous reset in the middle of a run, then a fresh run.
        sel = 0;
        do_start(16'd2);
        for (int i = 0; i < 10; i++) send_tap(8'sd4, 8'sd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6 async reset", 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(16'd2);
        send_pixel(1, 1, 1, 0, -300, -1);
        check("t6 literal 78", out_data[0], 78);
        send_pixel(-5, 1, 2, 1, 50, -1);
        wait_done("t6");

        check("queue drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
